instr_fetch_unit: RTL and testbench

// - Fetch stage directly upstream of control_unit in the single-cycle MIPS core.
// - Holds the PC and fetches one word per instruction from instruction memory over a req/ack handshake.
// - Presents instr (opcode/sa/func/imm fields) to control_unit; consumes npc_op back to compute the next PC.
// - Supplies pc_plus4 for the JAL link value (REG_SRC_JMP_DST path) and keeps a retired-instruction counter.

---
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the single-cycle MIPS core: PC, imem req/ack handshake, next-PC and retire count.
// Optional misaligned-target fault checking is enabled with `define FETCH_ALIGN_CHECK_EN.

`ifndef NPC_OP_LENGTH
`define NPC_OP_LENGTH 2
`endif
`ifndef NPC_OP_NEXT
`define NPC_OP_NEXT    2'b00
`define NPC_OP_OFFSET  2'b01
`define NPC_OP_JUMP    2'b10
`define NPC_OP_DEFAULT 2'b11
`endif

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic                      imem_ack,
  input  logic [31:0]               imem_rdata,
  input  logic                      hold,
  input  logic [`NPC_OP_LENGTH-1:0] npc_op,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic [CNT_WIDTH-1:0]      retired_cnt,
  output logic                      fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        load_instr;
  logic        commit;
  logic        misalign;
  logic        req_d;
  logic        valid_d;
  logic [31:0] p4;
  logic [31:0] npc_raw;
  logic [31:0] next_pc;

  // Next-PC selection; all adds wrap modulo 2^32
  always_comb begin
    p4 = pc + 32'd4;
    case (npc_op)
      `NPC_OP_NEXT:   npc_raw = p4;
      `NPC_OP_OFFSET: npc_raw = p4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      `NPC_OP_JUMP:   npc_raw = {p4[31:28], instr[25:0], 2'b00};
      default:        npc_raw = p4;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc = npc_raw;
`else
  // Without the checker a stray low-order bit can never reach the PC
  assign next_pc = npc_raw & 32'hFFFF_FFFC;
`endif

  assign pc_plus4  = p4;
  assign imem_addr = {pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    commit     = 1'b0;
    misalign   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          load_instr = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (!hold) begin
          commit  = 1'b1;
          state_d = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            misalign = 1'b1;
            state_d  = FAULT;
          end
`endif
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/valid flops are loaded from the next state so they line up with it
  assign req_d   = (state_d == FETCH);
  assign valid_d = (state_d == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      imem_req    <= req_d;
      instr_valid <= valid_d;
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (commit) begin
        retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      end
      if (commit && !misalign) begin
        pc <= next_pc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (misalign) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: default instance plus a small-counter instance with a
// misaligned reset PC to exercise wrap-around and target alignment handling.

`ifndef NPC_OP_LENGTH
`define NPC_OP_LENGTH 2
`endif
`ifndef NPC_OP_NEXT
`define NPC_OP_NEXT    2'b00
`define NPC_OP_OFFSET  2'b01
`define NPC_OP_JUMP    2'b10
`define NPC_OP_DEFAULT 2'b11
`endif

module tb_instr_fetch_unit;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      ack;
  logic [31:0]               rdata;
  logic                      hold;
  logic [`NPC_OP_LENGTH-1:0] npc_op;

  logic        u_req, u_valid, u_fault;
  logic [31:0] u_addr, u_instr, u_pc, u_p4, u_cnt;
  logic        b_req, b_valid, b_fault;
  logic [31:0] b_addr, b_instr, b_pc, b_p4;
  logic [1:0]  b_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(u_req), .imem_addr(u_addr), .imem_ack(ack),
    .imem_rdata(rdata), .hold(hold), .npc_op(npc_op), .instr(u_instr),
    .instr_valid(u_valid), .pc(u_pc), .pc_plus4(u_p4), .retired_cnt(u_cnt), .fault(u_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFE), .CNT_WIDTH(2)) b_dut (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr), .imem_ack(ack),
    .imem_rdata(rdata), .hold(hold), .npc_op(npc_op), .instr(b_instr),
    .instr_valid(b_valid), .pc(b_pc), .pc_plus4(b_p4), .retired_cnt(b_cnt), .fault(b_fault)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Leaves both DUTs in IDLE with rst low, at a falling edge
  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; hold = 1'b0; npc_op = `NPC_OP_NEXT; rdata = 32'd0;
    tick(1);
    rst = 1'b0;
  endtask

  // From FETCH: ack immediately, then leave EXEC with the given npc_op
  task automatic run_instr(input logic [31:0] word, input logic [1:0] op);
    ack = 1'b1; rdata = word; hold = 1'b0;
    tick(1);
    npc_op = op;
    tick(1);
    npc_op = `NPC_OP_NEXT;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b1; hold = 1'b0; npc_op = `NPC_OP_NEXT; rdata = 32'hFFFF_FFFF;
    tick(2);
    vectors++; if (u_pc !== 32'h0000_3000) begin miscompares++; $display("FAIL reset_pc got %h want 00003000", u_pc); end
    vectors++; if (u_instr !== 32'd0) begin miscompares++; $display("FAIL reset_instr got %h want 0", u_instr); end
    vectors++; if (u_valid !== 1'b0 || u_req !== 1'b0) begin miscompares++; $display("FAIL reset_valid_req got %b%b want 00", u_valid, u_req); end
    vectors++; if (u_cnt !== 32'd0 || u_fault !== 1'b0) begin miscompares++; $display("FAIL reset_cnt_fault got %h/%b want 0/0", u_cnt, u_fault); end
    vectors++; if (u_p4 !== 32'h0000_3004) begin miscompares++; $display("FAIL reset_pc_plus4 got %h want 00003004", u_p4); end
    rst = 1'b0; ack = 1'b0;
    tick(1);
    vectors++; if (u_req !== 1'b1 || u_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL idle_to_fetch req=%b addr=%h want 1/00003000", u_req, u_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    ack = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      rdata = 32'hA5A5_0000 + 32'(i);
      vectors++; if (u_req !== 1'b1 || u_valid !== 1'b0 || u_addr !== 32'h3000 + 32'(4 * i)) begin
        miscompares++; $display("FAIL seq_fetch%0d req=%b valid=%b addr=%h want 1/0/%h", i, u_req, u_valid, u_addr, 32'h3000 + 32'(4 * i));
      end
      tick(1);
      vectors++; if (u_valid !== 1'b1 || u_req !== 1'b0 || u_instr !== 32'hA5A5_0000 + 32'(i) || u_pc !== 32'h3000 + 32'(4 * i)) begin
        miscompares++; $display("FAIL seq_exec%0d valid=%b req=%b instr=%h pc=%h", i, u_valid, u_req, u_instr, u_pc);
      end
      tick(1);
    end
    vectors++; if (u_cnt !== 32'd3 || u_pc !== 32'h0000_300C) begin miscompares++; $display("FAIL seq_retired cnt=%0d pc=%h want 3/0000300c", u_cnt, u_pc); end
  endtask

  task automatic test_ack_delay();
    do_reset();
    tick(1);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (u_req !== 1'b1 || u_addr !== 32'h0000_3000 || u_instr !== 32'd0 || u_valid !== 1'b0) begin
        miscompares++; $display("FAIL ack_wait%0d req=%b addr=%h instr=%h valid=%b", k, u_req, u_addr, u_instr, u_valid);
      end
      if (k == 3) begin ack = 1'b1; rdata = 32'h1357_9BDF; end
      tick(1);
    end
    ack = 1'b0;
    vectors++; if (u_instr !== 32'h1357_9BDF || u_valid !== 1'b1 || u_req !== 1'b0) begin
      miscompares++; $display("FAIL ack_load instr=%h valid=%b req=%b want 13579bdf/1/0", u_instr, u_valid, u_req);
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    tick(1);
    repeat (4) run_instr(32'd0, `NPC_OP_NEXT);
    vectors++; if (u_pc !== 32'h0000_3010) begin miscompares++; $display("FAIL bj_pre_beq pc=%h want 00003010", u_pc); end
    run_instr(32'h1000_FFFC, `NPC_OP_OFFSET);
    vectors++; if (u_pc !== 32'h0000_3004 || u_addr !== 32'h0000_3004) begin miscompares++; $display("FAIL bj_beq pc=%h addr=%h want 00003004", u_pc, u_addr); end
    repeat (7) run_instr(32'd0, `NPC_OP_NEXT);
    vectors++; if (u_pc !== 32'h0000_3020) begin miscompares++; $display("FAIL bj_pre_jump pc=%h want 00003020", u_pc); end
    run_instr(32'h0800_0C40, `NPC_OP_JUMP);
    vectors++; if (u_pc !== 32'h0000_3100) begin miscompares++; $display("FAIL bj_jump pc=%h want 00003100", u_pc); end
    run_instr(32'h0800_0C40, `NPC_OP_DEFAULT);
    vectors++; if (u_pc !== 32'h0000_3104 || u_cnt !== 32'd14) begin miscompares++; $display("FAIL bj_default pc=%h cnt=%0d want 00003104/14", u_pc, u_cnt); end
  endtask

  task automatic test_hold();
    do_reset();
    tick(1);
    ack = 1'b1; rdata = 32'h0BAD_F00D;
    tick(1);
    hold = 1'b1; npc_op = `NPC_OP_JUMP;
    for (int h = 0; h < 2; h++) begin
      tick(1);
      vectors++; if (u_valid !== 1'b1 || u_req !== 1'b0 || u_pc !== 32'h0000_3000 || u_cnt !== 32'd0 || u_instr !== 32'h0BAD_F00D) begin
        miscompares++; $display("FAIL hold%0d valid=%b req=%b pc=%h cnt=%0d instr=%h", h, u_valid, u_req, u_pc, u_cnt, u_instr);
      end
    end
    hold = 1'b0; npc_op = `NPC_OP_NEXT;
    tick(1);
    vectors++; if (u_pc !== 32'h0000_3004 || u_cnt !== 32'd1 || u_valid !== 1'b0 || u_req !== 1'b1) begin
      miscompares++; $display("FAIL hold_release pc=%h cnt=%0d valid=%b req=%b want 00003004/1/0/1", u_pc, u_cnt, u_valid, u_req);
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    tick(1);
    run_instr(32'hDEAD_BEEF, `NPC_OP_NEXT);
    ack = 1'b0; rst = 1'b1;
    tick(1);
    vectors++; if (u_req !== 1'b0 || u_pc !== 32'h0000_3000 || u_instr !== 32'd0 || u_cnt !== 32'd0) begin
      miscompares++; $display("FAIL rst_fetch req=%b pc=%h instr=%h cnt=%0d", u_req, u_pc, u_instr, u_cnt);
    end
    rst = 1'b0; ack = 1'b1; rdata = 32'h0000_1234;
    tick(1);
    ack = 1'b0;
    vectors++; if (u_instr !== 32'd0 || u_valid !== 1'b0 || u_req !== 1'b1 || u_addr !== 32'h0000_3000) begin
      miscompares++; $display("FAIL rst_late_ack instr=%h valid=%b req=%b addr=%h", u_instr, u_valid, u_req, u_addr);
    end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    tick(1);
    ack = 1'b1; rdata = 32'h0000_0001;
    tick(1);
    ack = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vectors++; if (u_cnt !== 32'd0 || u_pc !== 32'h0000_3000 || u_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_exec cnt=%0d pc=%h valid=%b want 0/00003000/0", u_cnt, u_pc, u_valid);
    end
  endtask

  task automatic test_alignment();
    do_reset();
    tick(1);
    vectors++; if (b_addr !== 32'hFFFF_FFFC || b_pc !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL align_start addr=%h pc=%h want fffffffc/fffffffe", b_addr, b_pc);
    end
    run_instr(32'd0, `NPC_OP_NEXT);
`ifdef FETCH_ALIGN_CHECK_EN
    vectors++; if (b_fault !== 1'b1 || b_pc !== 32'hFFFF_FFFE || b_cnt !== 2'd1 || b_req !== 1'b0 || b_valid !== 1'b0) begin
      miscompares++; $display("FAIL align_fault fault=%b pc=%h cnt=%0d req=%b valid=%b", b_fault, b_pc, b_cnt, b_req, b_valid);
    end
    ack = 1'b1;
    tick(3);
    vectors++; if (b_fault !== 1'b1 || b_req !== 1'b0 || b_valid !== 1'b0 || u_fault !== 1'b0) begin
      miscompares++; $display("FAIL align_sticky fault=%b req=%b valid=%b main_fault=%b", b_fault, b_req, b_valid, u_fault);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0; ack = 1'b0;
    vectors++; if (b_fault !== 1'b0 || b_pc !== 32'hFFFF_FFFE || b_cnt !== 2'd0) begin
      miscompares++; $display("FAIL align_clear fault=%b pc=%h cnt=%0d", b_fault, b_pc, b_cnt);
    end
`else
    vectors++; if (b_pc !== 32'h0000_0000 || b_cnt !== 2'd1 || b_fault !== 1'b0 || b_req !== 1'b1) begin
      miscompares++; $display("FAIL align_force pc=%h cnt=%0d fault=%b req=%b want 00000000/1/0/1", b_pc, b_cnt, b_fault, b_req);
    end
    repeat (3) run_instr(32'd0, `NPC_OP_NEXT);
    vectors++; if (b_pc !== 32'h0000_000C || b_cnt !== 2'd0) begin
      miscompares++; $display("FAIL cnt_wrap pc=%h cnt=%0d want 0000000c/0", b_pc, b_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch_jump();
    test_hold();
    test_reset_mid_fetch();
    test_reset_in_exec();
    test_alignment();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
